// File: rtl/cs_pkg.sv
// Shared constants and types for the CS smoothing core and its output-side stages.
package cs_pkg;

    localparam int unsigned CS_X_W    = 8;
    localparam int unsigned CS_Y_W    = 10;
    localparam int unsigned CS_WINDOW = 9;
    localparam int unsigned CS_WARMUP = CS_WINDOW - 1;

    typedef logic [CS_Y_W-1:0] cs_y_t;

endpackage

// File: rtl/cs_sync_fifo.sv
// Synchronous FIFO with an explicit occupancy counter and a registered head word
// (no fall-through: a write into an empty FIFO is visible one cycle later).
module cs_sync_fifo #(
    parameter int unsigned W     = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_din,
    output logic [W-1:0]           o_dout,
    output logic                   o_valid,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_fill
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] FILL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] FILL_ONE  = (AW+1)'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;
    logic          r_valid;
    logic [W-1:0]  r_head;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_rd_next;
    logic [AW:0]   w_fill_nxt;

    assign w_full    = (r_fill == FILL_FULL);
    assign w_pop     = i_pop & r_valid;
    assign w_push    = i_push & (~w_full | w_pop);
    assign w_rd_next = r_rd_ptr + AW'(1);

    always_comb begin
        w_fill_nxt = r_fill;
        if (w_push && !w_pop) begin
            w_fill_nxt = r_fill + FILL_ONE;
        end else if (w_pop && !w_push) begin
            w_fill_nxt = r_fill - FILL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            r_fill  <= w_fill_nxt;
            r_valid <= (w_fill_nxt != '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            // Head reload: the next stored entry, or the incoming word when it is the only one left.
            if (w_pop) begin
                if (r_fill > FILL_ONE) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_push) begin
                    r_head <= i_din;
                end
            end else if (r_fill == '0 && w_push) begin
                r_head <= i_din;
            end
        end
    end

    assign o_dout  = r_head;
    assign o_valid = r_valid;
    assign o_full  = w_full;
    assign o_fill  = r_fill;

endmodule

// File: rtl/cs_y_buffer.sv
// Output stage after the CS core: drops warm-up results, then buffers valid Y
// samples in a FIFO drained over a valid/ready handshake.
module cs_y_buffer
    import cs_pkg::*;
#(
    parameter int unsigned Y_W    = CS_Y_W,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WARMUP = CS_WARMUP
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic [Y_W-1:0]         y_in,
    input  logic                   y_en,
    output logic [Y_W-1:0]         out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   warm,
    output logic                   overflow
);

    localparam int unsigned WCNT_W   = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int unsigned WLAST    = (WARMUP > 0) ? WARMUP - 1 : 0;
    localparam logic        WARM_RST = (WARMUP == 0);

    logic [WCNT_W-1:0] r_wcnt;
    logic              r_warm;
    logic              r_overflow;

    logic              w_rst;
    logic              w_push_req;
    logic              w_pop;
    logic              w_full;
    logic              w_drop;
    logic              w_valid;

    assign w_rst      = reset | clr;
    assign w_push_req = r_warm & y_en;
    assign w_pop      = w_valid & out_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign w_drop     = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_wcnt     <= '0;
            r_warm     <= WARM_RST;
            r_overflow <= 1'b0;
        end else begin
            if (!r_warm && y_en) begin
                if (r_wcnt == WCNT_W'(WLAST)) begin
                    r_warm <= 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    cs_sync_fifo #(
        .W     (Y_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (w_rst),
        .i_push  (w_push_req),
        .i_pop   (out_ready),
        .i_din   (y_in),
        .o_dout  (out_data),
        .o_valid (w_valid),
        .o_full  (w_full),
        .o_fill  (fill)
    );

    assign out_valid = w_valid;
    assign warm      = r_warm;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cs_y_buffer.sv
// Self-checking bench for cs_y_buffer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then a randomized phase.
module tb_cs_y_buffer;

    localparam int Y_W    = 10;
    localparam int DEPTH  = 16;
    localparam int WARMUP = 8;
    localparam int FW     = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset, clr, y_en, out_ready;
    logic [Y_W-1:0] y_in;
    logic [Y_W-1:0] out_data;
    logic           out_valid, warm, overflow;
    logic [FW-1:0]  fill;

    int errors = 0;
    int checks = 0;

    int q[$];
    int drained[$];
    int sent[$];
    int m_cnt  = 0;
    bit m_warm = 0;
    bit m_ovf  = 0;
    int max_fill = 0;

    always #5 clk = ~clk;

    cs_y_buffer #(
        .Y_W    (Y_W),
        .DEPTH  (DEPTH),
        .WARMUP (WARMUP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .y_in      (y_in),
        .y_en      (y_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill),
        .warm      (warm),
        .overflow  (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a plain queue, a pulse count and two flags.
    task automatic model_update();
        bit preq;
        if (reset || clr) begin
            q.delete();
            m_cnt  = 0;
            m_warm = (WARMUP == 0);
            m_ovf  = 0;
        end else begin
            preq = m_warm && y_en;
            if (q.size() > 0 && out_ready) drained.push_back(q.pop_front());
            if (preq) begin
                if (q.size() < DEPTH) q.push_back(int'(y_in));
                else m_ovf = 1;
            end
            if (!m_warm && y_en) begin
                m_cnt++;
                if (m_cnt == WARMUP) m_warm = 1;
            end
        end
    endtask

    task automatic compare();
        chk("fill", 32'(fill), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("warm", 32'(warm), 32'(m_warm));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
        if (int'(fill) > max_fill) max_fill = int'(fill);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic set_in(input bit en, input int val, input bit rdy);
        y_en      = en;
        y_in      = Y_W'(val);
        out_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic warm_up();
        for (int k = 0; k < WARMUP; k++) begin
            set_in(1, 32'h3F0 + k, 1);
            step();
        end
        set_in(0, 0, 1);
    endtask

    initial begin
        reset = 1'b0;
        clr   = 1'b0;
        set_in(0, 0, 0);

        // Reset values
        do_reset();
        chk("rst_fill", 32'(fill), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_warm", 32'(warm), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // Warm-up: 12 pulses 0x001..0x00C, only 0x009..0x00C survive
        drained.delete();
        for (int k = 1; k <= 12; k++) begin
            set_in(1, k, 1);
            step();
            if (k == 7) chk("warm_after7", 32'(warm), 0);
            if (k == 8) chk("warm_after8", 32'(warm), 1);
            if (k == 9) chk("first_out", 32'(out_data), 32'h009);
        end
        set_in(0, 0, 1);
        for (int k = 0; k < 3; k++) step();
        chk("warm_drain_n", 32'(drained.size()), 4);
        for (int k = 0; k < 4; k++) chk("warm_drain", 32'(drained[k]), 32'(9 + k));
        chk("warm_ovf", 32'(overflow), 0);

        // Stall and fill, then overflow on the 17th push
        for (int k = 0; k < 16; k++) begin
            set_in(1, 32'h100 + k, 0);
            step();
        end
        chk("stall_fill", 32'(fill), 16);
        chk("stall_head", 32'(out_data), 32'h100);
        set_in(1, 32'h3FF, 0);
        step();
        chk("stall_ovf", 32'(overflow), 1);
        chk("stall_fill17", 32'(fill), 16);
        drained.delete();
        set_in(0, 0, 1);
        for (int k = 0; k < 18; k++) step();
        chk("stall_drain_n", 32'(drained.size()), 16);
        for (int k = 0; k < 16; k++) chk("stall_drain", 32'(drained[k]), 32'(32'h100 + k));
        chk("stall_ovf_sticky", 32'(overflow), 1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        warm_up();
        for (int k = 0; k < 16; k++) begin
            set_in(1, 32'h100 + k, 0);
            step();
        end
        drained.delete();
        set_in(1, 32'h2AA, 1);
        step();
        chk("ss_fill", 32'(fill), 16);
        chk("ss_ovf", 32'(overflow), 0);
        chk("ss_head", 32'(out_data), 32'h101);
        set_in(0, 0, 1);
        for (int k = 0; k < 18; k++) step();
        chk("ss_drain_n", 32'(drained.size()), 17);
        chk("ss_last", 32'(drained[drained.size() - 1]), 32'h2AA);

        // Pointer wrap: 40 samples, out_ready toggling
        do_reset();
        warm_up();
        drained.delete();
        sent.delete();
        max_fill = 0;
        for (int i = 0; i < 200 && sent.size() < 40; i++) begin
            int v;
            bit en;
            v  = int'($urandom_range(0, 1023));
            en = (i < 16) || (i % 2 == 0);
            set_in(en, v, (i % 2 == 0));
            if (en) sent.push_back(v);
            step();
        end
        set_in(0, 0, 1);
        for (int k = 0; k < 30; k++) step();
        chk("wrap_n", 32'(drained.size()), 40);
        for (int k = 0; k < 40; k++) chk("wrap_data", 32'(drained[k]), 32'(sent[k]));
        chk("wrap_ovf", 32'(overflow), 0);
        chk("wrap_max_fill_le16", 32'(max_fill <= 16), 1);

        // Mid-stream clear with fill=5
        do_reset();
        warm_up();
        for (int k = 0; k < 5; k++) begin
            set_in(1, 32'h050 + k, 0);
            step();
        end
        chk("clr_pre_fill", 32'(fill), 5);
        clr = 1'b1;
        set_in(1, 32'h0AA, 1);
        step();
        clr = 1'b0;
        chk("clr_fill", 32'(fill), 0);
        chk("clr_valid", 32'(out_valid), 0);
        chk("clr_warm", 32'(warm), 0);
        chk("clr_ovf", 32'(overflow), 0);
        for (int k = 0; k < 8; k++) begin
            set_in(1, 32'h060 + k, 0);
            step();
            chk("clr_discard_fill", 32'(fill), 0);
        end
        chk("clr_rewarm", 32'(warm), 1);
        set_in(1, 32'h077, 0);
        step();
        chk("clr_first_push", 32'(fill), 1);
        set_in(0, 0, 0);
        step();
        chk("clr_first_data", 32'(out_data), 32'h077);

        // Randomized traffic with occasional clears
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            clr = ($urandom_range(0, 299) == 0);
            set_in(($urandom_range(0, 3) != 0), int'($urandom_range(0, 1023)),
                   ($urandom_range(0, 2) == 0) || (i > 1500 && $urandom_range(0, 1) == 0));
            step();
        end
        clr = 1'b0;
        set_in(0, 0, 1);
        for (int k = 0; k < 20; k++) step();
        chk("rand_empty", 32'(fill), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cs_y_buffer.md
# cs_y_buffer

Output-side stage placed directly downstream of the CS smoothing core. It samples CS's 10-bit `Y` stream, discards the warm-up outputs produced before CS's 9-sample window is full, and buffers the valid results in a small FIFO. The FIFO drains to the next consumer (output file writer, bus bridge, or checker) over a valid/ready handshake, so that consumer can stall without losing CS results.

## Interface
Parameters:
- `Y_W`, default 10: sample width; matches CS `Y`.
- `DEPTH`, default 16: FIFO entries; must be a power of two, at least 2.
- `WARMUP`, default 8: number of leading samples discarded after reset or `clr`.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `clr`  in  1: synchronous clear. Same effect as `reset` on all state, counters and flags.
- `y_in`  in  `Y_W`: CS `Y` output.
- `y_en`  in  1: `y_in` holds a new CS result this cycle (one per CS input sample).
- `out_data`  out  `Y_W`: FIFO head.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts `out_data` this cycle.
- `fill`  out  $clog2(DEPTH)+1: current occupancy.
- `warm`  out  1: warm-up finished; samples are now being stored.
- `overflow`  out  1: sticky. At least one post-warm-up sample was dropped because the FIFO was full.

## Operation
- Warm-up counter `wcnt` counts `y_en` pulses while `warm`=0.
  - The first `WARMUP` pulses are discarded.
  - On the `WARMUP`th pulse `warm` is set at that clock edge; that sample is still discarded.
  - Every later `y_en` is a push request.
  - With `WARMUP`=0, `warm`=1 from the first cycle after reset and every pulse is pushed.
- Push: `push_req` = `warm` & `y_en`. It is accepted when `fill`<`DEPTH`, or when `fill`==`DEPTH` and a pop also occurs in the same cycle.
- Pop: `out_valid` & `out_ready`.
- A `push_req` that is not accepted drops the sample, sets `overflow`, and leaves FIFO contents untouched.
- Same-cycle push and pop:
  - `fill` is unchanged.
  - When `fill`==1, the popped entry leaves and the pushed entry becomes the head on the next cycle.
- `out_valid` = (`fill`!=0). No fall-through: a sample written into an empty FIFO appears on `out_data` one cycle later.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. `fill` is kept as an explicit counter, not derived from the pointers.
- `out_data` is the registered head entry. It is held stable while `out_valid`=1 and `out_ready`=0.
- `out_data` is don't-care when `out_valid`=0, but it must never be X after reset.
- No arithmetic is performed on samples; values pass through bit-exact.
- `reset`/`clr` asserted mid-stream:
  - Empties the FIFO and zeroes the pointers.
  - Clears `warm`, `wcnt` and `overflow`.
  - Any pending push or pop in that cycle is ignored.
  - The warm-up restarts from 0 pulses.

## Timing
- Reset values, effective the cycle after `reset`/`clr` is sampled high: `out_valid`=0, `out_data`=0, `fill`=0, `warm`=0, `overflow`=0.
- Latency from `y_en` (post-warm-up) to `out_valid` is 1 cycle when the FIFO was empty.
- Sustained throughput is 1 sample per cycle when `out_ready`=1 continuously.
- `fill`, `warm` and `overflow` are registered and update at the edge where the event is sampled.
- Inputs are sampled at the rising edge. All outputs come directly from flops, with no combinational path from `out_ready` to `out_data`. This gives the downstream consumer clean setup/hold margins.

## Structure
- Shared package `cs_pkg` holds:
  - `CS_X_W`=8 and `CS_Y_W`=10.
  - `CS_WINDOW`=9, with default `WARMUP` = `CS_WINDOW`-1.
  - The typedef `cs_y_t` (`logic [CS_Y_W-1:0]`).
- One sub-module, `cs_sync_fifo`, contains the storage array, pointers, `fill` counter and full/empty logic. The top module contains the warm-up counter, the push qualification and the overflow flag.

## Test plan
- **Warm-up:** reset, then 12 consecutive `y_en` with `y_in`=0x001…0x00C and `out_ready`=1. Samples 1–8 are dropped and `warm` rises after pulse 8. `out_data` shows 0x009, 0x00A, 0x00B, 0x00C on consecutive cycles, and `overflow`=0.
- **Stall and fill:** after warm-up, `out_ready`=0 with 16 pushes of 0x100+k. `fill`=16 and `out_valid`=1 with `out_data`=0x100 held. A 17th push of 0x3FF is dropped and sets `overflow`=1. After releasing `out_ready`, entries drain in order 0x100…0x10F and `overflow` stays 1.
- **Full with simultaneous push/pop:** with `fill`=16, assert `out_ready`=1 and push 0x2AA in the same cycle. `fill` stays 16, `overflow` stays 0, and 0x2AA is the last entry drained.
- **Pointer wrap:** stream 40 post-warm-up samples with `out_ready` toggling 1,0,1,0. All 40 values emerge in order with none lost, and `fill` never exceeds 16.
- **Mid-stream clear:** with `fill`=5, assert `clr` for one cycle during a push. The next cycle shows `fill`=0, `out_valid`=0, `warm`=0 and `overflow`=0, and 8 further pulses are again discarded.
- **CS-level check:** connect CS to this block using the `in.dat`/`out_golden.dat` pattern set with `out_ready`=1. The drained sequence matches the golden file entry-for-entry.
